// File: rtl/aes256_byte_collector_if.sv
// Handshake and data bundle between the byte collector, its upstream loader and the block consumer.
// The collector uses the slave modport; the environment driving it uses master.
interface aes256_byte_collector_if #(
  parameter int unsigned NUM_BYTES = 16
);
  localparam int unsigned CntW = $clog2(NUM_BYTES + 1);

  logic                     pi_key_ready;
  logic                     pi_start;
  logic                     po_next_val_req;
  logic                     pi_next_val_ready;
  logic [7:0]               pi_data;
  logic [NUM_BYTES*8-1:0]   po_block;
  logic                     po_block_valid;
  logic                     pi_block_ack;
  logic                     po_busy;
  logic [CntW-1:0]          po_byte_cnt;
  logic                     po_error;

  modport master (
    output pi_key_ready, pi_start, pi_next_val_ready, pi_data, pi_block_ack,
    input  po_next_val_req, po_block, po_block_valid, po_busy, po_byte_cnt, po_error
  );

  modport slave (
    input  pi_key_ready, pi_start, pi_next_val_ready, pi_data, pi_block_ack,
    output po_next_val_req, po_block, po_block_valid, po_busy, po_byte_cnt, po_error
  );
endinterface

// File: rtl/aes256_byte_collector.sv
// Requests bytes one at a time from an upstream loader and assembles them MSB-first into a block,
// holding the block until acknowledged; a per-byte wait timeout latches a sticky error.
module aes256_byte_collector #(
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic                    clk,
  input logic                    rst,
  aes256_byte_collector_if.slave bus
);
  localparam int unsigned CntW   = $clog2(NUM_BYTES + 1);
  localparam int unsigned TimerW = $clog2(TIMEOUT);
  localparam int unsigned BlockW = NUM_BYTES * 8;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StErr} state_e;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic [BlockW-1:0]   block_q;
  logic [CntW-1:0]     cnt_q;
  logic                req_q;
  logic                busy_q;
  logic                valid_q;
  logic                error_q;

  // All outputs are flops set alongside the state they belong to, so no input reaches them
  // combinationally. req/busy/valid default low and are re-asserted on entry to or stay in
  // the states that own them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      block_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.pi_start && bus.pi_key_ready) begin
            state_q <= StReq;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StReq: begin
          if (!bus.pi_key_ready) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            block_q <= '0;
          end else begin
            state_q <= StWait;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        StWait: begin
          if (!bus.pi_key_ready) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            block_q <= '0;
          end else if (bus.pi_next_val_ready) begin
            // A strobe on the final timer cycle still wins over the timeout.
            block_q <= {block_q[BlockW-9:0], bus.pi_data};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CntW'(NUM_BYTES - 1)) begin
              state_q <= StHold;
              valid_q <= 1'b1;
            end else begin
              state_q <= StReq;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
            state_q <= StErr;
            error_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StHold: begin
          if (bus.pi_block_ack) begin
            if (bus.pi_start && bus.pi_key_ready) begin
              state_q <= StReq;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            valid_q <= 1'b1;
          end
        end
        StErr: begin
          if (bus.pi_start) begin
            state_q <= StIdle;
            error_q <= 1'b0;
            cnt_q   <= '0;
            block_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.po_next_val_req = req_q;
  assign bus.po_block        = block_q;
  assign bus.po_block_valid  = valid_q;
  assign bus.po_busy         = busy_q;
  assign bus.po_byte_cnt     = cnt_q;
  assign bus.po_error        = error_q;
endmodule

// File: doc/aes256_byte_collector.md
AES256_BYTE_COLLECTOR -- requirements
Module: aes256_byte_collector

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_BYTES, 16, bytes assembled per output block.
REQ-003 Parameter TIMEOUT, 64, maximum WAIT cycles allowed per byte before an error is raised.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 pi_key_ready  in  1  high when the upstream key expansion is complete; this is the enable for collection.
REQ-007 pi_start  in  1  one-cycle request to collect one block.
REQ-008 po_next_val_req  out  1  one-cycle byte request to the upstream loading stage.
REQ-009 pi_next_val_ready  in  1  one-cycle strobe qualifying pi_data.
REQ-010 pi_data  in  8  byte from the upstream loading stage.
REQ-011 po_block  out  128  assembled block; the first byte received occupies [127:120].
REQ-012 po_block_valid  out  1  po_block is complete and stable.
REQ-013 pi_block_ack  in  1  consumer accepts po_block.
REQ-014 po_busy  out  1  high in states REQ and WAIT.
REQ-015 po_byte_cnt  out  5  number of bytes captured in the current block (0..16).
REQ-016 po_error  out  1  timeout flag; sticky.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, REQ, WAIT, HOLD and ERR.
REQ-018 IDLE: pi_start with pi_key_ready=1 -> REQ and clear po_byte_cnt to 0; pi_start with pi_key_ready=0 SHALL be ignored.
REQ-019 REQ: drive po_next_val_req=1 for exactly one cycle, clear the timeout timer, then go to WAIT.
REQ-020 WAIT: on pi_next_val_ready=1, shift pi_data into po_block (MSB-first: block <= {block[119:0], pi_data}) and increment po_byte_cnt.
REQ-021 From WAIT after a byte is captured: if po_byte_cnt reaches NUM_BYTES -> HOLD, else -> REQ; each byte therefore costs at least 2 cycles.
REQ-022 WAIT without a strobe: increment the timer; when the timer equals TIMEOUT-1 with no strobe -> ERR and set po_error=1.
REQ-023 A strobe arriving on the same cycle the timer reaches TIMEOUT-1 SHALL be accepted, and no error is raised.
REQ-024 pi_next_val_ready SHALL be ignored in IDLE, REQ, HOLD and ERR; po_block and po_byte_cnt stay unchanged.
REQ-025 pi_key_ready falling while in REQ or WAIT SHALL abort to IDLE on the next edge, with po_byte_cnt=0 and the partial data discarded.
REQ-026 HOLD: po_block_valid=1 and po_block held constant until pi_block_ack=1.
REQ-027 In HOLD, pi_block_ack alone -> IDLE; pi_block_ack together with pi_start and pi_key_ready -> REQ directly, with po_byte_cnt=0.
REQ-028 pi_start in HOLD without pi_block_ack SHALL be ignored.
REQ-029 pi_start in REQ or WAIT SHALL be ignored.
REQ-030 ERR: po_error stays 1; pi_start -> IDLE, clearing po_error, po_byte_cnt and po_block.
REQ-031 po_block_valid and po_next_val_req SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-032 rst=1 SHALL force state IDLE, set po_block=0, po_block_valid=0, po_next_val_req=0, po_busy=0, po_byte_cnt=0, po_error=0 and clear the timer, on the next edge.
REQ-033 rst SHALL take priority over every input in every state, including mid-block and in ERR.

Verification
REQ-034 Nominal: pi_key_ready=1, pulse pi_start; upstream answers each request 1 cycle later with bytes 0x00..0x0F -> 16 request pulses; then po_block=128'h000102030405060708090A0B0C0D0E0F with po_block_valid=1 and po_byte_cnt=16.
REQ-035 Hold and ack: withhold pi_block_ack for 10 cycles -> po_block_valid and po_block stay stable; ack together with pi_start -> REQ on the next cycle with po_byte_cnt=0.
REQ-036 Timeout: no strobe after the 3rd request -> po_error=1 exactly 64 cycles after entering WAIT; pi_start -> IDLE with po_error=0; a strobe at cycle 63 instead -> accepted, no error.
REQ-037 Key drop: deassert pi_key_ready after 5 bytes -> IDLE with po_byte_cnt=0 and no po_block_valid; pi_start with pi_key_ready=0 -> no request issued.
REQ-038 Reset mid-operation: rst after 7 bytes -> all outputs 0 on the next edge; a following nominal run gives a correct block.
REQ-039 Stray strobe: pi_next_val_ready pulsed in IDLE and HOLD -> po_block and po_byte_cnt unchanged.
